// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt request unit: default channel count,
// trigger-mode encoding and the default-width request vector type.
package pic_pkg;

    localparam int NUM_IRQ_DEFAULT = 8;

    // Encoding of level_or_edge_flag
    localparam logic LEVEL = 1'b1;
    localparam logic EDGE  = 1'b0;

    typedef logic [NUM_IRQ_DEFAULT-1:0] irq_vec_t;

endpackage

// File: rtl/irq_request_unit_if.sv
// Request/control bundle of the interrupt request unit.
// master: the side that drives request lines and control (CPU / stimulus).
// slave : the request unit itself.
interface irq_request_unit_if #(
    parameter int NUM_IRQ = pic_pkg::NUM_IRQ_DEFAULT,
    parameter int IDX_W   = $clog2(NUM_IRQ)
);
    logic [NUM_IRQ-1:0] ir_in;
    logic               level_or_edge_flag;
    logic               freeze;
    logic [NUM_IRQ-1:0] clear_interrupt_request;
    logic [NUM_IRQ-1:0] mask;
    logic               rotate_en;
    logic [IDX_W-1:0]   rotate_lowest;
    logic [NUM_IRQ-1:0] irr;
    logic               int_req;
    logic [IDX_W-1:0]   int_idx;

    modport master (
        output ir_in, level_or_edge_flag, freeze, clear_interrupt_request,
               mask, rotate_en, rotate_lowest,
        input  irr, int_req, int_idx
    );

    modport slave (
        input  ir_in, level_or_edge_flag, freeze, clear_interrupt_request,
               mask, rotate_en, rotate_lowest,
        output irr, int_req, int_idx
    );
endinterface

// File: rtl/irq_priority_resolver.sv
// Combinational rotating-priority search. base is the lowest-priority
// channel; the search starts at base+1 and walks upward with wrap-around.
module irq_priority_resolver import pic_pkg::*; #(
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);
    int ch;

    // First set request found walking up from base+1 (mod NUM_IRQ)
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        valid = 1'b0;
        idx   = '0;
        ch    = 0;
        for (int k = 1; k <= NUM_IRQ; k++) begin
            ch = int'(base) + k;
            if (ch >= NUM_IRQ) ch = ch - NUM_IRQ;
            if (!valid && req[ch[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = ch[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/irq_request_unit.sv
// Interrupt request unit: edge/level capture into the IRR, freeze-time
// deferral via a pending register, per-channel clears, masking and a
// rotating-priority registered request/index output.
// Optional macro IRQ_SYNC_EN: passes ir_in through a 2-flop synchroniser.
module irq_request_unit import pic_pkg::*; #(
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input logic              clk,
    input logic              reset,
    irq_request_unit_if.slave bus
);
    typedef logic [NUM_IRQ-1:0] vec_t;

    localparam logic [IDX_W-1:0] BASE_RST = IDX_W'(NUM_IRQ - 1);

    vec_t             ir_s;
    vec_t             ir_prev;
    vec_t             set_cond;
    vec_t             irr_q;
    vec_t             irr_next;
    vec_t             pending_q;
    vec_t             pending_next;
    vec_t             masked;
    logic             level_mode;
    logic             res_valid;
    logic [IDX_W-1:0] res_idx;
    logic [IDX_W-1:0] base_q;
    logic             rot_ok;
    logic             int_req_q;
    logic [IDX_W-1:0] int_idx_q;

`ifdef IRQ_SYNC_EN
    vec_t sync1;
    vec_t sync2;

    // Two-flop synchroniser; all-ones reset so a line high through reset is not an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.ir_in;
            sync2 <= sync1;
        end
    end

    assign ir_s = sync2;
`else
    assign ir_s = bus.ir_in;
`endif

    assign level_mode = (bus.level_or_edge_flag == LEVEL);

    // Previous sample of the request lines for edge detection
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) ir_prev <= '1;
        else       ir_prev <= ir_s;
    end

    // Per-bit set condition: level follows the line, edge is a 0->1 transition
    always_comb begin
        set_cond = level_mode ? ir_s : (ir_s & ~ir_prev);
    end

    // IRR / pending update: clears always act, sets are deferred while frozen
    always_comb begin
        irr_next     = irr_q;
        pending_next = pending_q;
        if (bus.freeze) begin
            pending_next = pending_q | set_cond;
            irr_next     = irr_q & ~bus.clear_interrupt_request;
        end else begin
            irr_next = irr_q & ~bus.clear_interrupt_request;
            if (level_mode) irr_next = irr_next & ir_s;
            // Sets are ORed last so a same-cycle set beats a clear or a drop
            irr_next     = irr_next | set_cond | pending_q;
            pending_next = '0;
        end
    end

    // IRR and pending registers
    always_ff @(posedge clk) begin
        if (reset) begin
            irr_q     <= '0;
            pending_q <= '0;
        end else begin
            irr_q     <= irr_next;
            pending_q <= pending_next;
        end
    end

    // Mask gates only the request/index path, never the IRR itself
    assign masked = irr_q & ~bus.mask;

    irq_priority_resolver #(
        .NUM_IRQ(NUM_IRQ),
        .IDX_W  (IDX_W)
    ) u_resolver (
        .req  (masked),
        .base (base_q),
        .valid(res_valid),
        .idx  (res_idx)
    );

    // A rotate request is honoured only for an existing channel index
    always_comb begin
        rot_ok = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.rotate_lowest == i[IDX_W-1:0]) rot_ok = 1'b1;
        end
    end

    // Priority base and registered request/index; index holds when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q    <= BASE_RST;
            int_req_q <= 1'b0;
            int_idx_q <= '0;
        end else begin
            if (bus.rotate_en && rot_ok) base_q <= bus.rotate_lowest;
            int_req_q <= res_valid;
            if (res_valid) int_idx_q <= res_idx;
        end
    end

    assign bus.irr     = irr_q;
    assign bus.int_req = int_req_q;
    assign bus.int_idx = int_idx_q;
endmodule

// File: tb/tb_irq_request_unit.sv
// Scoreboard bench for irq_request_unit: a driver applies one input vector
// per cycle, runs the behavioural model and queues the expected outputs;
// a monitor pops one expectation per clock and compares.
module tb_irq_request_unit;
    import pic_pkg::*;

    localparam int N  = NUM_IRQ_DEFAULT;
    localparam int IW = $clog2(N);

    typedef struct {
        irq_vec_t        irr;
        logic            req;
        logic [IW-1:0]   idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    irq_request_unit_if #(.NUM_IRQ(N), .IDX_W(IW)) bus ();

    irq_request_unit #(.NUM_IRQ(N), .IDX_W(IW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Stimulus for the next edge
    logic          rst_v     = 1'b1;
    irq_vec_t      ir_v      = '0;
    logic          lvl_v     = EDGE;
    logic          frz_v     = 1'b0;
    irq_vec_t      clr_v     = '0;
    irq_vec_t      msk_v     = '0;
    logic          rot_en_v  = 1'b0;
    logic [IW-1:0] rot_low_v = '0;

    // Reference model state
    irq_vec_t      irr_m  = '0;
    irq_vec_t      pend_m = '0;
    irq_vec_t      prev_m = '1;
    irq_vec_t      s1_m   = '1;
    irq_vec_t      s2_m   = '1;
    int            base_m = N - 1;
    logic          req_m  = 1'b0;
    logic [IW-1:0] idx_m  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock of the behavioural model, from the rules of the unit
    task automatic model_cycle();
        irq_vec_t masked;
        irq_vec_t line;
        logic     found;
        logic     rise;
        logic     trig;
        int       c;
        exp_t     e;
        if (rst_v) begin
            irr_m  = '0;
            pend_m = '0;
            prev_m = '1;
            s1_m   = '1;
            s2_m   = '1;
            base_m = N - 1;
            req_m  = 1'b0;
            idx_m  = '0;
        end else begin
`ifdef IRQ_SYNC_EN
            line = s2_m;
            s2_m = s1_m;
            s1_m = ir_v;
`else
            line = ir_v;
`endif
            // Outputs reflect the IRR as it stood before this edge
            masked = irr_m & ~msk_v;
            req_m  = (masked != '0);
            found  = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (base_m + k) % N;
                if (!found && masked[c]) begin
                    found = 1'b1;
                    idx_m = c[IW-1:0];
                end
            end
            if (rot_en_v && int'(rot_low_v) < N) base_m = int'(rot_low_v);
            for (int b = 0; b < N; b++) begin
                rise = line[b] && !prev_m[b];
                trig = (lvl_v == LEVEL) ? line[b] : rise;
                if (frz_v) begin
                    if (trig) pend_m[b] = 1'b1;
                    if (clr_v[b]) irr_m[b] = 1'b0;
                end else begin
                    irr_m[b]  = trig || pend_m[b] ||
                                (irr_m[b] && !clr_v[b] && (lvl_v != LEVEL || line[b]));
                    pend_m[b] = 1'b0;
                end
            end
            prev_m = line;
        end
        e.irr = irr_m;
        e.req = req_m;
        e.idx = idx_m;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus; pulse inputs self-clear afterwards
    task automatic step();
        @(negedge clk);
        reset                       = rst_v;
        bus.ir_in                   = ir_v;
        bus.level_or_edge_flag      = lvl_v;
        bus.freeze                  = frz_v;
        bus.clear_interrupt_request = clr_v;
        bus.mask                    = msk_v;
        bus.rotate_en               = rot_en_v;
        bus.rotate_lowest           = rot_low_v;
        model_cycle();
        clr_v    = '0;
        rot_en_v = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expectation per sampling edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("irr",     32'(bus.irr),     32'(e.irr));
                check("int_req", 32'(bus.int_req), 32'(e.req));
                check("int_idx", 32'(bus.int_idx), 32'(e.idx));
            end
        end
    end

    initial begin
        // Lines held high across reset release in edge mode
        rst_v = 1'b1;
        ir_v  = '1;
        repeat (3) step();
        rst_v = 1'b0;
        repeat (3) step();
`ifndef IRQ_SYNC_EN
        settle();
        check("hold_high_reset_irr", 32'(bus.irr), 32'h00);
`endif
        ir_v = '0;
        repeat (2) step();

        // Single rising edge on channel 3
        ir_v = 8'h08;
        step();
`ifndef IRQ_SYNC_EN
        settle();
        check("edge3_irr", 32'(bus.irr), 32'h08);
        check("edge3_req_early", 32'(bus.int_req), 32'h0);
`endif
        step();
`ifndef IRQ_SYNC_EN
        settle();
        check("edge3_req", 32'(bus.int_req), 32'h1);
        check("edge3_idx", 32'(bus.int_idx), 32'h3);
`endif
        clr_v = 8'h08;
        step();
        ir_v = '0;
        step();

        // Rising edge and clear on the same bit
        ir_v  = 8'h10;
        clr_v = 8'h10;
        step();
`ifndef IRQ_SYNC_EN
        settle();
        check("set_beats_clear", 32'(bus.irr), 32'h10);
`endif
        clr_v = 8'h10;
        step();
        ir_v = '0;
        step();

        // Freeze: clear acts, new edge deferred to the release cycle
        ir_v = 8'h04;
        step();
        ir_v = '0;
        step();
        frz_v = 1'b1;
        ir_v  = 8'h02;
        clr_v = 8'h04;
        step();
`ifndef IRQ_SYNC_EN
        settle();
        check("freeze_irr", 32'(bus.irr), 32'h00);
`endif
        step();
        frz_v = 1'b0;
        step();
`ifndef IRQ_SYNC_EN
        settle();
        check("unfreeze_irr", 32'(bus.irr), 32'h02);
`endif
        ir_v  = '0;
        clr_v = 8'h02;
        step();

        // Masking and rotation with channels 0 and 7 pending
        ir_v = 8'h81;
        step();
        ir_v = '0;
        step();
        msk_v = 8'h01;
        step();
`ifndef IRQ_SYNC_EN
        settle();
        check("mask0_idx", 32'(bus.int_idx), 32'h7);
`endif
        msk_v = 8'h00;
        step();
`ifndef IRQ_SYNC_EN
        settle();
        check("nomask_idx", 32'(bus.int_idx), 32'h0);
`endif
        rot_en_v  = 1'b1;
        rot_low_v = '0;
        step();
        step();
`ifndef IRQ_SYNC_EN
        settle();
        check("rotate_idx", 32'(bus.int_idx), 32'h7);
`endif
        rot_en_v  = 1'b1;
        rot_low_v = IW'(N - 1);
        step();
        clr_v = 8'h81;
        step();

        // Level mode: held line survives a clear, drop clears the bit
        lvl_v = LEVEL;
        ir_v  = 8'h20;
        step();
`ifndef IRQ_SYNC_EN
        settle();
        check("level_set", 32'(bus.irr), 32'h20);
`endif
        clr_v = 8'h20;
        step();
`ifndef IRQ_SYNC_EN
        settle();
        check("level_clear_held", 32'(bus.irr), 32'h20);
`endif
        ir_v = '0;
        step();
`ifndef IRQ_SYNC_EN
        settle();
        check("level_drop", 32'(bus.irr), 32'h00);
`endif
        lvl_v = EDGE;
        step();

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            rst_v = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0)
                ir_v = ir_v ^ irq_vec_t'(1 << $urandom_range(0, N - 1));
            else if ($urandom_range(0, 9) == 0)
                ir_v = irq_vec_t'($urandom());
            if ($urandom_range(0, 39) == 0) lvl_v = ~lvl_v;
            if ($urandom_range(0, 5) == 0) frz_v = ~frz_v;
            clr_v = ($urandom_range(0, 3) == 0) ? irq_vec_t'($urandom()) : '0;
            if ($urandom_range(0, 7) == 0) msk_v = irq_vec_t'($urandom());
            rot_en_v  = ($urandom_range(0, 9) == 0);
            rot_low_v = IW'($urandom_range(0, N - 1));
            step();
        end

        rst_v = 1'b0;
        frz_v = 1'b0;
        repeat (2) step();
        repeat (3) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
